// File: rtl/gcd_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_arb_pkg
//  Description : Shared constants for the GCD engine arbiter: FSM state
//                encoding, default operand width, requester id width and
//                the round-robin pointer advance helper.
//  Revision    : 1.0  initial release
// ============================================================================
package gcd_arb_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;
    localparam logic [1:0] c_ST_RESP = 2'd3;

    // Default operand/result width
    localparam int c_W_DEFAULT = 32;

    // Requester index width; covers up to 8 requesters
    localparam int c_ID_W = 3;

    // Next round-robin start point: one past the served requester, wrapping
    function automatic logic [c_ID_W-1:0] rr_next(
        input logic [c_ID_W-1:0] id,
        input logic [c_ID_W-1:0] last_id
    );
        return (id == last_id) ? '0 : id + c_ID_W'(1);
    endfunction

endpackage : gcd_arb_pkg
`default_nettype wire

// File: rtl/gcd_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_rr_pick
//  Description : Combinational round-robin picker. Returns the first set
//                request bit at or after the pointer, wrapping N-1 -> 0.
//  Revision    : 1.0  initial release
// ============================================================================
module gcd_rr_pick
    import gcd_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]      i_req,
    input  logic [c_ID_W-1:0] i_rr_ptr,
    output logic              o_valid,
    output logic [c_ID_W-1:0] o_id
);

    localparam logic [c_ID_W:0] c_N_EXT = (c_ID_W+1)'(N);

    // Request vector widened to the full id range so any id indexes safely
    logic [(1<<c_ID_W)-1:0] w_req_ext;
    assign w_req_ext = (1<<c_ID_W)'(i_req);

    // Scan offsets from highest to lowest so the smallest offset wins
    always_comb begin
        logic [c_ID_W:0] v_sum;
        o_valid = 1'b0;
        o_id    = '0;
        v_sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            v_sum = {1'b0, i_rr_ptr} + (c_ID_W+1)'(k);
            if (v_sum >= c_N_EXT) begin
                v_sum = v_sum - c_N_EXT;
            end
            if (w_req_ext[v_sum[c_ID_W-1:0]]) begin
                o_valid = 1'b1;
                o_id    = v_sum[c_ID_W-1:0];
            end
        end
    end

endmodule : gcd_rr_pick
`default_nettype wire

// File: rtl/gcd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_arbiter
//  Description : Shares one GCD engine among N requesters. Grants round-robin,
//                latches operands, pulses eng_go, waits for eng_done and
//                returns the result with a one-cycle one-hot ack. Operands
//                with a zero are answered directly (a|b) without the engine.
//  Options     : GCD_ARB_TIMEOUT_EN - abort a RUN that lasts TIMEOUT cycles,
//                pulsing eng_rst and answering with rsp_err=1, rsp_data=0.
//  Revision    : 1.0  initial release
// ============================================================================
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = c_W_DEFAULT,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*W-1:0]    req_a,
    input  logic [N*W-1:0]    req_b,
    output logic [N-1:0]      ack,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [c_ID_W-1:0] grant_id,
    output logic              eng_go,
    output logic [W-1:0]      eng_a,
    output logic [W-1:0]      eng_b,
    output logic              eng_rst,
    input  logic [W-1:0]      eng_out,
    input  logic              eng_done
);

    localparam logic [c_ID_W-1:0] c_LAST_ID = c_ID_W'(N - 1);
    localparam logic [N-1:0]      c_ONE     = {{(N-1){1'b0}}, 1'b1};

    // Elaboration-time parameter sanity
    if (N < 2 || N > 8) begin : g_bad_n
        $error("gcd_arbiter: N must be in 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("gcd_arbiter: TIMEOUT must be at least 1");
    end

    logic [1:0]        r_state;
    logic [c_ID_W-1:0] r_rr_ptr;

    logic              w_pick_valid;
    logic [c_ID_W-1:0] w_pick_id;
    logic [W-1:0]      w_pick_a;
    logic [W-1:0]      w_pick_b;

    gcd_rr_pick #(
        .N (N)
    ) u_pick (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_id     (w_pick_id)
    );

    assign w_pick_a = req_a[w_pick_id*W +: W];
    assign w_pick_b = req_b[w_pick_id*W +: W];

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_run_cnt;
    logic               r_err;
`endif

    // Main FSM with operand latches, result capture and RUN cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_rr_ptr <= '0;
            grant_id <= '0;
            eng_a    <= '0;
            eng_b    <= '0;
            rsp_data <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
            r_run_cnt <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pick_valid) begin
                        grant_id <= w_pick_id;
                        eng_a    <= w_pick_a;
                        eng_b    <= w_pick_b;
`ifdef GCD_ARB_TIMEOUT_EN
                        r_err     <= 1'b0;
                        r_run_cnt <= '0;
`endif
                        // A zero operand makes the GCD the other operand
                        if (w_pick_a == '0 || w_pick_b == '0) begin
                            rsp_data <= w_pick_a | w_pick_b;
                            r_state  <= c_ST_RESP;
                        end else begin
                            r_state  <= c_ST_LOAD;
                        end
                    end
                end
                c_ST_LOAD: begin
                    r_state <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (eng_done) begin
                        rsp_data <= eng_out;
                        r_state  <= c_ST_RESP;
                    end
`ifdef GCD_ARB_TIMEOUT_EN
                    else if (r_run_cnt == c_CNT_LAST) begin
                        rsp_data <= '0;
                        r_err    <= 1'b1;
                        r_state  <= c_ST_RESP;
                    end else begin
                        r_run_cnt <= r_run_cnt + c_CNT_W'(1);
                    end
`endif
                end
                c_ST_RESP: begin
                    r_rr_ptr <= rr_next(grant_id, c_LAST_ID);
                    r_state  <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Single-cycle strobes decoded from the state register
    assign busy   = (r_state != c_ST_IDLE);
    assign eng_go = (r_state == c_ST_LOAD);
    assign ack    = (r_state == c_ST_RESP) ? (c_ONE << grant_id) : '0;

`ifdef GCD_ARB_TIMEOUT_EN
    assign rsp_err = r_err;
    assign eng_rst = (r_state == c_ST_RESP) && r_err;
`else
    assign rsp_err = 1'b0;
    assign eng_rst = 1'b0;
`endif

endmodule : gcd_arbiter
`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_arbiter
//  Description : Scoreboard bench for gcd_arbiter with a behavioural GCD
//                engine and per-requester client drivers.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gcd_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   ack;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           busy;
    logic [2:0]     grant_id;
    logic           eng_go;
    logic [W-1:0]   eng_a;
    logic [W-1:0]   eng_b;
    logic           eng_rst;
    logic [W-1:0]   eng_out;
    logic           eng_done;

    gcd_arbiter #(
        .N       (N),
        .W       (W),
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_a    (req_a),
        .req_b    (req_b),
        .ack      (ack),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .grant_id (grant_id),
        .eng_go   (eng_go),
        .eng_a    (eng_a),
        .eng_b    (eng_b),
        .eng_rst  (eng_rst),
        .eng_out  (eng_out),
        .eng_done (eng_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int           id;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- client drivers ----------------
    logic [N-1:0] start = '0;
    logic [N-1:0] kill  = '0;
    logic [W-1:0] st_a [N];
    logic [W-1:0] st_b [N];

    initial begin
        logic [N-1:0] ackd;
        req   = '0;
        req_a = '0;
        req_b = '0;
        forever begin
            @(negedge clk);
            ackd = ack;
            @(posedge clk);
            #1;
            req   = req & ~ackd & ~kill;
            start = start & ~kill;
            kill  = '0;
            for (int i = 0; i < N; i++) begin
                if (start[i]) begin
                    req[i]            = 1'b1;
                    req_a[i*W +: W]   = st_a[i];
                    req_b[i*W +: W]   = st_b[i];
                    start[i]          = 1'b0;
                end
            end
        end
    end

    // ---------------- behavioural GCD engine ----------------
    int eng_lat = 3;
    bit stuck   = 1'b0;

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    initial begin
        bit           e_busy;
        int           e_cnt;
        logic [W-1:0] e_a;
        logic [W-1:0] e_b;
        e_busy   = 1'b0;
        e_cnt    = 0;
        e_a      = '0;
        e_b      = '0;
        eng_done = 1'b0;
        eng_out  = '0;
        forever begin
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (rst || eng_rst) begin
                e_busy = 1'b0;
            end else if (e_busy) begin
                if (e_cnt <= 1) begin
                    eng_done = 1'b1;
                    eng_out  = gcd_f(e_a, e_b);
                    e_busy   = 1'b0;
                end else begin
                    e_cnt--;
                end
            end else if (eng_go) begin
                e_busy = !stuck;
                e_a    = eng_a;
                e_b    = eng_b;
                e_cnt  = eng_lat;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        exp_t         e;
        logic [W-1:0] one;
        one = 1;
        forever begin
            @(negedge clk);
            if (!rst && ack != '0) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: actual=%b required=none", ack);
                end else begin
                    e = q.pop_front();
                    chk("ack_onehot", W'(ack), one << e.id);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", W'(rsp_err), W'(e.err));
                    chk("eng_rst_at_ack", W'(eng_rst), W'(e.err));
                end
            end
        end
    end

    // ---------------- stimulus helpers (call right after a negedge) ----------------
    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input logic err, input bit want_ack);
        st_a[id]  = a;
        st_b[id]  = b;
        start[id] = 1'b1;
        if (want_ack) q.push_back('{id, exp, err});
    endtask

    task automatic wait_ack(input int id, input int budget);
        int c;
        c = 0;
        while (!ack[id] && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (!ack[id]) begin
            n_err++;
            $display("FAIL wait_ack%0d: actual=no ack required=ack within %0d cycles", id, budget);
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((q.size() != 0 || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (q.size() != 0 || busy) begin
            n_err++;
            $display("FAIL drain: actual=%0d pending busy=%b required=0 pending idle", q.size(), busy);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), 0);
        chk("rst_ack", W'(ack), 0);
        chk("rst_grant_id", W'(grant_id), 0);
        chk("rst_eng_a", eng_a, 0);
        chk("rst_eng_b", eng_b, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", W'(rsp_err), 0);
        chk("rst_eng_go", W'(eng_go), 0);
        chk("rst_eng_rst", W'(eng_rst), 0);
        rst = 1'b0;
        @(negedge clk);

        // All four request together from rr_ptr=0; requester 0 comes back
        issue(0, 48, 18, 6, 1'b0, 1'b1);
        issue(1, 100, 75, 25, 1'b0, 1'b1);
        issue(2, 17, 5, 1, 1'b0, 1'b1);
        issue(3, 0, 0, 0, 1'b0, 1'b1);
        wait_ack(0, 50);
        issue(0, 32'hFFFF_FFFF, 5, 5, 1'b0, 1'b1);
        drain(300);

        // req[3] arrives while req[1] is in service (rr_ptr=1)
        eng_lat = 6;
        issue(1, 21, 14, 7, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("t6_busy_in_run", W'(busy), 1);
        issue(3, 100, 75, 25, 1'b0, 1'b1);
        wait_ack(1, 50);
        @(negedge clk);
        chk("t6_idle_after_ack", W'(busy), 0);
        @(negedge clk);
        chk("t6_eng_go", W'(eng_go), 1);
        chk("t6_grant_id", W'(grant_id), 3);
        drain(100);

        // Single request through the engine (rr_ptr=0)
        eng_lat = 3;
        issue(0, 48, 18, 6, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_idle_busy", W'(busy), 0);
        chk("t1_idle_go", W'(eng_go), 0);
        @(negedge clk);
        chk("t1_eng_go", W'(eng_go), 1);
        chk("t1_grant_id", W'(grant_id), 0);
        chk("t1_eng_a", eng_a, 48);
        chk("t1_eng_b", eng_b, 18);
        @(negedge clk);
        chk("t1_go_one_cycle", W'(eng_go), 0);
        chk("t1_eng_a_stable", eng_a, 48);
        drain(100);

        // Zero operand bypasses the engine
        issue(2, 0, 35, 35, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t3_ack", W'(ack), 32'h4);
        chk("t3_no_go", W'(eng_go), 0);
        chk("t3_rsp_data", rsp_data, 35);
        drain(50);

        // Simultaneous requests from rr_ptr=3 -> 3, 0, 1
        issue(3, 12, 18, 6, 1'b0, 1'b1);
        issue(0, 1234, 0, 1234, 1'b0, 1'b1);
        issue(1, 81, 27, 27, 1'b0, 1'b1);
        drain(200);

        // Reset in RUN aborts without ack
        eng_lat = 20;
        issue(0, 48, 18, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("t4_busy_run", W'(busy), 1);
        rst  = 1'b1;
        kill = '1;
        #1;
        chk("t4_busy_after_rst", W'(busy), 0);
        chk("t4_ack_after_rst", W'(ack), 0);
        repeat (2) @(negedge clk);
        chk("t4_grant_id_rst", W'(grant_id), 0);
        rst = 1'b0;
        @(negedge clk);
        eng_lat = 3;
        issue(1, 21, 14, 7, 1'b0, 1'b1);
        drain(100);

`ifdef GCD_ARB_TIMEOUT_EN
        // Engine never finishes -> abort after 16 RUN cycles
        stuck = 1'b1;
        issue(2, 9, 6, 0, 1'b1, 1'b1);
        drain(100);
        stuck = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_gcd_arbiter
`default_nettype wire
